// File: rtl/imem_load_ctrl_if.sv
// Loader, CPU-fetch and instruction-memory signal bundle for imem_load_ctrl.
// master = the controller, slave = the loader/CPU/memory environment around it.
interface imem_load_ctrl_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
);
  // Program loader stream
  logic              ld_start;
  logic              ld_valid;
  logic [DATA_W-1:0] ld_data;
  logic              ld_last;
  logic              ld_ready;

  // CPU instruction fetch
  logic              cpu_req;
  logic [31:0]       cpu_pc;
  logic [DATA_W-1:0] cpu_instr;
  logic              cpu_valid;
  logic              cpu_stall;

  // Single-port instruction memory, registered read data
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    input  ld_start, ld_valid, ld_data, ld_last,
    input  cpu_req, cpu_pc,
    input  mem_rdata,
    output ld_ready,
    output cpu_instr, cpu_valid, cpu_stall,
    output mem_addr, mem_we, mem_wdata
  );

  modport slave (
    output ld_start, ld_valid, ld_data, ld_last,
    output cpu_req, cpu_pc,
    output mem_rdata,
    input  ld_ready,
    input  cpu_instr, cpu_valid, cpu_stall,
    input  mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/imem_load_ctrl.sv
// Boot-load / fetch controller: streams loader words into instruction memory while
// the CPU is stalled, then hands the memory read port to byte-PC instruction fetch.
module imem_load_ctrl #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  imem_load_ctrl_if.master bus,
  output logic             pc_fault,
  output logic             boot_done,
  output logic [ADDR_W:0]  load_count,
  output logic             err_overflow
);

  localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W + 1)'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [ADDR_W:0]   r_wr_ptr;
  logic              r_err_overflow;
  logic              r_pc_fault;
  logic              r_fetch_vld;
  logic              r_fetch_flt;

  logic              w_ld_ready;
  logic              w_accept;
  logic              w_full;
  logic              w_wr_en;
  logic              w_drop;
  logic              w_fetch;
  logic              w_pc_bad;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [DATA_W-1:0] w_mem_wdata;

  // The write pointer saturates at DEPTH, so its MSB alone means "memory full".
  assign w_full   = r_wr_ptr[ADDR_W];
  assign w_pc_bad = (|bus.cpu_pc[1:0]) | (|bus.cpu_pc[31:ADDR_W+2]);

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    w_state_nxt = r_state;
    w_ld_ready  = 1'b0;
    w_accept    = 1'b0;
    w_wr_en     = 1'b0;
    w_drop      = 1'b0;
    w_fetch     = 1'b0;
    w_mem_addr  = '0;
    w_mem_wdata = '0;

    unique case (r_state)
      ST_IDLE: begin
        if (bus.ld_start) w_state_nxt = ST_LOAD;
      end

      ST_LOAD: begin
        // A restart pulse wins over any word offered in the same cycle.
        w_ld_ready = ~bus.ld_start;
        w_accept   = bus.ld_valid & w_ld_ready;
        w_wr_en    = w_accept & ~w_full;
        w_drop     = w_accept & w_full;
        if (w_wr_en) begin
          w_mem_addr  = r_wr_ptr[ADDR_W-1:0];
          w_mem_wdata = bus.ld_data;
        end
        if (w_accept && bus.ld_last) w_state_nxt = ST_RUN;
      end

      ST_RUN: begin
        if (bus.cpu_req) w_mem_addr = bus.cpu_pc[ADDR_W+1:2];
        if (bus.ld_start) begin
          w_state_nxt = ST_LOAD;
        end else begin
          w_fetch = bus.cpu_req;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Session bookkeeping: any ld_start opens a fresh session from word 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr       <= '0;
      r_err_overflow <= 1'b0;
    end else if (bus.ld_start) begin
      r_wr_ptr       <= '0;
      r_err_overflow <= 1'b0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + CNT_ONE;
      if (w_drop)  r_err_overflow <= 1'b1;
    end
  end

  // One fetch in flight per cycle, tracked alongside the memory's read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_vld <= 1'b0;
      r_fetch_flt <= 1'b0;
      r_pc_fault  <= 1'b0;
    end else begin
      r_fetch_vld <= w_fetch;
      r_fetch_flt <= w_fetch & w_pc_bad;
      if (w_fetch && w_pc_bad) r_pc_fault <= 1'b1;
    end
  end

  assign bus.ld_ready  = w_ld_ready;
  assign bus.mem_we    = w_wr_en;
  assign bus.mem_addr  = w_mem_addr;
  assign bus.mem_wdata = w_mem_wdata;
  assign bus.cpu_stall = (r_state != ST_RUN);
  assign bus.cpu_valid = r_fetch_vld;
  assign bus.cpu_instr = (r_fetch_vld && !r_fetch_flt) ? bus.mem_rdata : '0;

  assign boot_done    = (r_state == ST_RUN);
  assign load_count   = r_wr_ptr;
  assign err_overflow = r_err_overflow;
  assign pc_fault     = r_pc_fault;

endmodule
